mem_rsp_agent: RTL and testbench

MEM_RSP_AGENT -- requirements
Module: mem_rsp_agent

---
 rtl/cache_pkg.sv | 21 ++
 rtl/mem_rsp_ram.sv | 25 ++
 rtl/mem_rsp_agent.sv | 137 +++++++++++++
 tb/tb_mem_rsp_agent.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared opcode/response encodings and the memory response agent state type.
package cache_pkg;

    localparam logic [2:0] SDREQ_RD  = 3'b000;
    localparam logic [2:0] SDREQ_RFO = 3'b001;
    localparam logic [2:0] SDREQ_WB  = 3'b010;
    localparam logic [2:0] SDREQ_INV = 3'b011;

    localparam logic [2:0] SURSP_OKAY  = 3'b000;
    localparam logic [2:0] SURSP_FETCH = 3'b001;
    localparam logic [2:0] SURSP_SNOOP = 3'b010;
    localparam logic [2:0] SURSP_ERR   = 3'b111;

    typedef enum logic [1:0] {
        AGENT_IDLE,
        AGENT_ACCEPT,
        AGENT_PROC,
        AGENT_RSP
    } agent_state_t;

endpackage

// File: rtl/mem_rsp_ram.sv
// Backing block store: single port, synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_rsp_ram #(
    parameter int BLK_WIDTH = 512,
    parameter int MEM_BLK   = 1024,
    localparam int IDX_W    = $clog2(MEM_BLK)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     idx,
    input  logic [BLK_WIDTH-1:0] wdata,
    output logic [BLK_WIDTH-1:0] rdata
);

    logic [BLK_WIDTH-1:0] mem [MEM_BLK];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_rsp_agent.sv
// Memory-side agent serving one cache request at a time with a fixed
// processing latency, tracking per-block sharers for FETCH/SNOOP replies.
module mem_rsp_agent
    import cache_pkg::*;
#(
    parameter int PADDR_WIDTH = 64,
    parameter int BLK_WIDTH   = 512,
    parameter int MEM_BLK     = 1024,
    parameter int RD_LAT      = 4,
    parameter int SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH/8)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sdreq_valid,
    input  logic [2:0]             sdreq_op,
    input  logic [SADDR_WIDTH-1:0] sdreq_addr,
    input  logic [BLK_WIDTH-1:0]   sdreq_data,
    output logic                   sdreq_ready,
    output logic                   sursp_valid,
    output logic [2:0]             sursp_rsp,
    output logic [BLK_WIDTH-1:0]   sursp_data,
    input  logic                   sursp_ready
);

    localparam int IDX_W = $clog2(MEM_BLK);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    agent_state_t         state;
    agent_state_t         next_state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           op_q;
    logic [IDX_W-1:0]     idx_q;
    logic [BLK_WIDTH-1:0] data_q;
    logic [MEM_BLK-1:0]   shr;
    logic                 ram_we;
    logic [BLK_WIDTH-1:0] ram_rdata;
    logic                 proc_last;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^sdreq_addr[SADDR_WIDTH-1:IDX_W];
    assign proc_last = (state == AGENT_PROC) && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= AGENT_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            AGENT_IDLE:   if (sdreq_valid) next_state = AGENT_ACCEPT;
            AGENT_ACCEPT: next_state = AGENT_PROC;
            AGENT_PROC:   if (cnt == CNT_W'(1)) next_state = AGENT_RSP;
            AGENT_RSP:    if (sursp_ready) next_state = AGENT_IDLE;
            default:      next_state = AGENT_IDLE;
        endcase
    end

    // The write-back commits during the first PROC cycle so an async reset
    // inside PROC suppresses it combinationally.
    always_comb begin
        sdreq_ready = (state == AGENT_ACCEPT);
        sursp_valid = (state == AGENT_RSP);
        ram_we      = (state == AGENT_PROC) && (cnt == CNT_W'(RD_LAT)) &&
                      (op_q == SDREQ_WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == AGENT_ACCEPT) begin
            cnt <= CNT_W'(RD_LAT);
        end else if (state == AGENT_PROC) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == AGENT_ACCEPT) begin
            op_q   <= sdreq_op;
            idx_q  <= sdreq_addr[IDX_W-1:0];
            data_q <= sdreq_data;
        end
    end

    // Response is classified from the sharer bit as it stood before this
    // request; the sharer update lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sursp_rsp  <= '0;
            sursp_data <= '0;
            shr        <= '0;
        end else if (proc_last) begin
            case (op_q)
                SDREQ_RD: begin
                    sursp_rsp  <= shr[idx_q] ? SURSP_SNOOP : SURSP_FETCH;
                    sursp_data <= ram_rdata;
                    shr[idx_q] <= 1'b1;
                end
                SDREQ_RFO: begin
                    sursp_rsp  <= SURSP_FETCH;
                    sursp_data <= ram_rdata;
                    shr[idx_q] <= 1'b1;
                end
                SDREQ_INV: begin
                    sursp_rsp  <= SURSP_OKAY;
                    sursp_data <= '0;
                    shr[idx_q] <= 1'b1;
                end
                SDREQ_WB: begin
                    sursp_rsp  <= SURSP_OKAY;
                    sursp_data <= '0;
                    shr[idx_q] <= 1'b0;
                end
                default: begin
                    sursp_rsp  <= SURSP_ERR;
                    sursp_data <= '0;
                end
            endcase
        end
    end

    mem_rsp_ram #(
        .BLK_WIDTH(BLK_WIDTH),
        .MEM_BLK  (MEM_BLK)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .idx  (idx_q),
        .wdata(data_q),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_mem_rsp_agent.sv
// Randomized self-checking bench for mem_rsp_agent against a block-level
// reference model of memory contents and sharer state.
module tb_mem_rsp_agent;
    import cache_pkg::*;

    localparam int PW      = 64;
    localparam int BW      = 512;
    localparam int MEM_BLK = 1024;
    localparam int RD_LAT  = 4;
    localparam int SAW     = PW - $clog2(BW/8);
    localparam int IDX_W   = $clog2(MEM_BLK);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           sdreq_valid;
    logic [2:0]     sdreq_op;
    logic [SAW-1:0] sdreq_addr;
    logic [BW-1:0]  sdreq_data;
    logic           sdreq_ready;
    logic           sursp_valid;
    logic [2:0]     sursp_rsp;
    logic [BW-1:0]  sursp_data;
    logic           sursp_ready;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] mem_m [MEM_BLK];
    bit            shr_m [MEM_BLK];

    mem_rsp_agent #(
        .PADDR_WIDTH(PW),
        .BLK_WIDTH  (BW),
        .MEM_BLK    (MEM_BLK),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sdreq_valid(sdreq_valid),
        .sdreq_op   (sdreq_op),
        .sdreq_addr (sdreq_addr),
        .sdreq_data (sdreq_data),
        .sdreq_ready(sdreq_ready),
        .sursp_valid(sursp_valid),
        .sursp_rsp  (sursp_rsp),
        .sursp_data (sursp_data),
        .sursp_ready(sursp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] d;
        for (int i = 0; i < BW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Reference behaviour: what the memory agent should answer for a request.
    task automatic model_txn(input logic [2:0] op, input logic [SAW-1:0] addr,
                             input logic [BW-1:0] wdata,
                             output logic [2:0] er, output logic [BW-1:0] ed);
        int idx;
        idx = int'(addr % SAW'(MEM_BLK));
        er = SURSP_ERR;
        ed = '0;
        if (op == SDREQ_RD) begin
            er = shr_m[idx] ? SURSP_SNOOP : SURSP_FETCH;
            ed = mem_m[idx];
            shr_m[idx] = 1'b1;
        end else if (op == SDREQ_RFO) begin
            er = SURSP_FETCH;
            ed = mem_m[idx];
            shr_m[idx] = 1'b1;
        end else if (op == SDREQ_INV) begin
            er = SURSP_OKAY;
            shr_m[idx] = 1'b1;
        end else if (op == SDREQ_WB) begin
            er = SURSP_OKAY;
            mem_m[idx] = wdata;
            shr_m[idx] = 1'b0;
        end
    endtask

    // Issues one request with sursp_ready held high; reports cycle numbers
    // (counted from the edge that samples sdreq_valid) or -1 on timeout.
    task automatic do_txn(input logic [2:0] op, input logic [SAW-1:0] addr,
                          input logic [BW-1:0] wdata,
                          output logic [2:0] rsp, output logic [BW-1:0] rdata,
                          output int ready_cyc, output int valid_cyc);
        sdreq_op    = op;
        sdreq_addr  = addr;
        sdreq_data  = wdata;
        sdreq_valid = 1'b1;
        sursp_ready = 1'b1;
        ready_cyc   = -1;
        valid_cyc   = -1;
        rsp         = 'x;
        rdata       = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (sdreq_ready && ready_cyc < 0) ready_cyc = c;
            if (ready_cyc > 0 && c == ready_cyc + 1) sdreq_valid = 1'b0;
            if (sursp_valid) begin
                valid_cyc = c;
                rsp       = sursp_rsp;
                rdata     = sursp_data;
                break;
            end
        end
        sdreq_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        sdreq_valid = 1'b1;
        sdreq_op    = SDREQ_RD;
        sdreq_addr  = '0;
        sdreq_data  = '0;
        sursp_ready = 1'b0;
        for (int i = 0; i < 16; i++) shr_m[i] = 1'b0;
        for (int i = 0; i < MEM_BLK; i++) shr_m[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sdreq_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_sdreq_ready: got %b expected 0", sdreq_ready);
        end
        checks++;
        if (sursp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_sursp_valid: got %b expected 0", sursp_valid);
        end
        checks++;
        if (sursp_rsp !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_sursp_rsp: got %h expected 0", sursp_rsp);
        end
        checks++;
        if (sursp_data !== '0) begin
            errors++; $display("[TB] FAIL reset_sursp_data: got %h expected 0", sursp_data);
        end
        sdreq_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sdreq_ready !== 1'b0 || sursp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got ready=%b valid=%b expected 0/0", sdreq_ready, sursp_valid);
        end
    endtask

    task automatic test_latency();
        logic [2:0] rsp, er; logic [BW-1:0] rd, ed; int rc, vc;
        model_txn(SDREQ_WB, SAW'(12'h010), {64{8'hA5}}, er, ed);
        do_txn(SDREQ_WB, SAW'(12'h010), {64{8'hA5}}, rsp, rd, rc, vc);
        checks++;
        if (rc !== 1) begin
            errors++; $display("[TB] FAIL latency_ready_cycle: got %0d expected 1", rc);
        end
        checks++;
        if (vc !== RD_LAT + 2) begin
            errors++; $display("[TB] FAIL latency_valid_cycle: got %0d expected %0d", vc, RD_LAT + 2);
        end
        checks++;
        if (rsp !== SURSP_OKAY || rsp !== er) begin
            errors++; $display("[TB] FAIL latency_rsp: got %h expected %h", rsp, SURSP_OKAY);
        end
        checks++;
        if (rd !== '0) begin
            errors++; $display("[TB] FAIL latency_data: got %h expected 0", rd);
        end
    endtask

    task automatic test_shared();
        logic [2:0] rsp, er; logic [BW-1:0] rd, ed, wb; int rc, vc;
        logic [2:0] exp_seq [3];
        exp_seq[0] = SURSP_FETCH; exp_seq[1] = SURSP_SNOOP; exp_seq[2] = SURSP_FETCH;
        wb = rand_blk();
        for (int s = 0; s < 3; s++) begin
            if (s == 2) begin
                model_txn(SDREQ_WB, SAW'(12'h010), wb, er, ed);
                do_txn(SDREQ_WB, SAW'(12'h010), wb, rsp, rd, rc, vc);
            end
            model_txn(SDREQ_RD, SAW'(12'h010), '0, er, ed);
            do_txn(SDREQ_RD, SAW'(12'h010), '0, rsp, rd, rc, vc);
            checks++;
            if (rsp !== exp_seq[s] || rsp !== er) begin
                errors++; $display("[TB] FAIL shared_rsp%0d: got %h expected %h", s, rsp, exp_seq[s]);
            end
            checks++;
            if (rd !== ed || (s < 2 && rd !== {64{8'hA5}})) begin
                errors++; $display("[TB] FAIL shared_data%0d: got %h expected %h", s, rd, ed);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] er, held_rsp; logic [BW-1:0] ed, held_data; bit seen;
        model_txn(SDREQ_RD, SAW'(12'h010), '0, er, ed);
        sdreq_op    = SDREQ_RD;
        sdreq_addr  = SAW'(12'h010);
        sdreq_data  = '0;
        sdreq_valid = 1'b1;
        sursp_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(posedge clk); #1;
            seen = sursp_valid;
        end
        held_rsp  = sursp_rsp;
        held_data = sursp_data;
        checks++;
        if (!seen || held_rsp !== er || held_data !== ed) begin
            errors++;
            $display("[TB] FAIL bp_first: got valid=%b rsp=%h expected valid=1 rsp=%h", seen, held_rsp, er);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (sursp_valid !== 1'b1 || sursp_rsp !== held_rsp || sursp_data !== held_data ||
                sdreq_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b rsp=%h ready=%b expected 1/%h/0",
                         c, sursp_valid, sursp_rsp, sdreq_ready, held_rsp);
            end
        end
        sdreq_valid = 1'b0;
        sursp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sursp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_release: got valid=%b expected 0", sursp_valid);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] rsp, er; logic [BW-1:0] rd, ed; int rc, vc;
        model_txn(3'b101, SAW'(12'h010), rand_blk(), er, ed);
        do_txn(3'b101, SAW'(12'h010), rand_blk(), rsp, rd, rc, vc);
        checks++;
        if (rsp !== SURSP_ERR || rd !== '0) begin
            errors++; $display("[TB] FAIL illegal_rsp: got %h expected %h with zero data", rsp, SURSP_ERR);
        end
        model_txn(SDREQ_RD, SAW'(12'h010), '0, er, ed);
        do_txn(SDREQ_RD, SAW'(12'h010), '0, rsp, rd, rc, vc);
        checks++;
        if (rsp !== er || rd !== ed) begin
            errors++; $display("[TB] FAIL illegal_followup: got %h expected %h", rsp, er);
        end
    endtask

    task automatic test_reset_abort();
        logic [2:0] rsp, er; logic [BW-1:0] rd, ed, pre, post; int rc, vc; bit bad;
        pre  = rand_blk();
        post = ~pre;
        model_txn(SDREQ_WB, SAW'(12'h020), pre, er, ed);
        do_txn(SDREQ_WB, SAW'(12'h020), pre, rsp, rd, rc, vc);
        model_txn(SDREQ_RD, SAW'(12'h020), '0, er, ed);
        do_txn(SDREQ_RD, SAW'(12'h020), '0, rsp, rd, rc, vc);
        sdreq_op    = SDREQ_WB;
        sdreq_addr  = SAW'(12'h020);
        sdreq_data  = post;
        sdreq_valid = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        sdreq_valid = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        #1;
        checks++;
        if (sursp_valid !== 1'b0 || sdreq_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_in_reset: got valid=%b ready=%b expected 0/0", sursp_valid, sdreq_ready);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < MEM_BLK; i++) shr_m[i] = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (sursp_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("[TB] FAIL abort_no_rsp: got a response expected none");
        end
        model_txn(SDREQ_RD, SAW'(12'h020), '0, er, ed);
        do_txn(SDREQ_RD, SAW'(12'h020), '0, rsp, rd, rc, vc);
        checks++;
        if (rsp !== SURSP_FETCH || rd !== pre || rd !== ed) begin
            errors++; $display("[TB] FAIL abort_followup: got rsp=%h data=%h expected %h/%h", rsp, rd, SURSP_FETCH, pre);
        end
    endtask

    task automatic test_alias();
        logic [2:0] rsp, er; logic [BW-1:0] rd, ed, wb; int rc, vc;
        wb = rand_blk();
        model_txn(SDREQ_WB, SAW'(12'h400), wb, er, ed);
        do_txn(SDREQ_WB, SAW'(12'h400), wb, rsp, rd, rc, vc);
        model_txn(SDREQ_RD, SAW'(12'h000), '0, er, ed);
        do_txn(SDREQ_RD, SAW'(12'h000), '0, rsp, rd, rc, vc);
        checks++;
        if (rd !== wb || rsp !== er) begin
            errors++; $display("[TB] FAIL alias_rd: got rsp=%h data=%h expected %h/%h", rsp, rd, er, wb);
        end
    endtask

    task automatic test_random();
        logic [2:0] rsp, er, op; logic [BW-1:0] rd, ed, wd; int rc, vc;
        logic [SAW-1:0] addr; logic [63:0] r64;
        logic [IDX_W-1:0] pool [6];
        for (int i = 0; i < 6; i++) begin
            pool[i] = IDX_W'($urandom_range(64, MEM_BLK - 1));
            wd = rand_blk();
            model_txn(SDREQ_WB, SAW'(pool[i]), wd, er, ed);
            do_txn(SDREQ_WB, SAW'(pool[i]), wd, rsp, rd, rc, vc);
        end
        for (int n = 0; n < 40; n++) begin
            r64  = {$urandom, $urandom};
            addr = r64[SAW-1:0];
            addr[IDX_W-1:0] = pool[$urandom_range(0, 5)];
            op = 3'($urandom_range(0, 7));
            wd = rand_blk();
            model_txn(op, addr, wd, er, ed);
            do_txn(op, addr, wd, rsp, rd, rc, vc);
            checks++;
            if (vc !== RD_LAT + 2 || rsp !== er || rd !== ed) begin
                errors++;
                $display("[TB] FAIL random%0d op=%h: got lat=%0d rsp=%h expected lat=%0d rsp=%h (data match=%b)",
                         n, op, vc, rsp, RD_LAT + 2, er, rd === ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_shared();
        test_backpressure();
        test_illegal();
        test_reset_abort();
        test_alias();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
